// File: rtl/axi4_burst_master.sv
// axi4_burst_master: AXI4 manager that turns one command (plus a write-data
// or read-data stream) into a single INCR burst on AW/W/B or AR/R.
// Only one transaction is in flight at a time.
//
// Valid/ready semantics on every channel: a transfer happens on a rising ACLK
// edge where VALID and READY are both high; a VALID source holds VALID and its
// payload stable until that edge and never waits for READY before asserting.
//
// Optional build macro AXI4_MASTER_TIMEOUT_EN: adds err_timeout and a watchdog
// that aborts a stalled transaction after TIMEOUT_CYCLES idle cycles (reported
// as rsp_valid with rsp_resp=2'b10) and flags BID/RID mismatches.
module axi4_burst_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  // command stream
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  // write-data stream
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  // read-data stream
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  // completion
  output logic                    rsp_valid,
  output logic [1:0]              rsp_resp,
  // AW channel
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [7:0]              AWLEN,
  output logic [2:0]              AWSIZE,
  output logic [1:0]              AWBURST,
  output logic [ID_WIDTH-1:0]     AWID,
  // W channel
  output logic                    WVALID,
  input  logic                    WREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WLAST,
  // B channel
  input  logic                    BVALID,
  output logic                    BREADY,
  input  logic [1:0]              BRESP,
  input  logic [ID_WIDTH-1:0]     BID,
  // AR channel
  output logic                    ARVALID,
  input  logic                    ARREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic [7:0]              ARLEN,
  output logic [2:0]              ARSIZE,
  output logic [1:0]              ARBURST,
  output logic [ID_WIDTH-1:0]     ARID,
  // R channel
  input  logic                    RVALID,
  output logic                    RREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RLAST,
  input  logic [ID_WIDTH-1:0]     RID,
  // debug view of the FSM state (encoding of state_t)
  output logic [2:0]              fsm_state
`ifdef AXI4_MASTER_TIMEOUT_EN
  ,
  output logic                    err_timeout
`endif
);

  localparam logic [2:0] AX_SIZE  = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_AW    = 3'd1,
    S_WDATA = 3'd2,
    S_BRESP = 3'd3,
    S_AR    = 3'd4,
    S_RDATA = 3'd5
  } state_t;

  state_t                state;
  logic [7:0]            len_q;
  logic [7:0]            beat_cnt;
  logic [ID_WIDTH-1:0]   id_q;
  logic [1:0]            resp_acc;
  logic [1:0]            resp_next;
  logic                  in_w, in_r;
  logic                  cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign fsm_state = state;

  // Data streams pass straight through while their burst phase is active and
  // are forced low otherwise, so a reset or idle state never leaks a beat.
  assign in_w     = (state == S_WDATA);
  assign in_r     = (state == S_RDATA);
  assign WVALID   = in_w & wr_valid;
  assign wr_ready = in_w & WREADY;
  assign WDATA    = in_w ? wr_data : '0;
  assign WSTRB    = in_w ? wr_strb : '0;
  assign WLAST    = in_w & (beat_cnt == len_q);
  assign rd_valid = in_r & RVALID;
  assign RREADY   = in_r & rd_ready;
  assign rd_data  = in_r ? RDATA : '0;
  assign rd_last  = in_r & RLAST;

  assign cmd_hs = cmd_valid & cmd_ready;
  assign aw_hs  = AWVALID & AWREADY;
  assign w_hs   = WVALID & WREADY;
  assign b_hs   = BVALID & BREADY;
  assign ar_hs  = ARVALID & ARREADY;
  assign r_hs   = RVALID & RREADY;

  // Worst-so-far read response including the beat being accepted now.
  assign resp_next = (RRESP > resp_acc) ? RRESP : resp_acc;

`ifdef AXI4_MASTER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            any_hs, id_err, wd_hit;

  assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;
  assign id_err = (b_hs && (BID != id_q)) || (r_hs && (RID != id_q));
  assign wd_hit = (state != S_IDLE) && !any_hs && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: count stalled cycles of an active burst; errors stay set until reset
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if ((state == S_IDLE) || any_hs || wd_hit) wd_cnt <= '0;
      else                                       wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_hit || id_err) err_timeout <= 1'b1;
    end
  end
`else
  // Response IDs are not checked in this build; the watchdog limit is unused.
  logic unused_sink;
  assign unused_sink = ^{BID, RID, id_q, (TIMEOUT_CYCLES == 0)};
`endif

  // Burst sequencer: command capture, address phases, beat counting, completion
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_resp  <= 2'b00;
      AWVALID   <= 1'b0;
      AWADDR    <= '0;
      AWLEN     <= '0;
      AWSIZE    <= '0;
      AWBURST   <= '0;
      AWID      <= '0;
      ARVALID   <= 1'b0;
      ARADDR    <= '0;
      ARLEN     <= '0;
      ARSIZE    <= '0;
      ARBURST   <= '0;
      ARID      <= '0;
      BREADY    <= 1'b0;
      len_q     <= '0;
      beat_cnt  <= '0;
      id_q      <= '0;
      resp_acc  <= 2'b00;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          // cmd_ready rises one cycle after entering IDLE, so the completion
          // cycle never accepts a new command.
          if (cmd_hs) begin
            cmd_ready <= 1'b0;
            len_q     <= cmd_len;
            id_q      <= cmd_id;
            beat_cnt  <= '0;
            resp_acc  <= 2'b00;
            if (cmd_write) begin
              AWVALID <= 1'b1;
              AWADDR  <= cmd_addr;
              AWLEN   <= cmd_len;
              AWSIZE  <= AX_SIZE;
              AWBURST <= BURST_INCR;
              AWID    <= cmd_id;
              state   <= S_AW;
            end else begin
              ARVALID <= 1'b1;
              ARADDR  <= cmd_addr;
              ARLEN   <= cmd_len;
              ARSIZE  <= AX_SIZE;
              ARBURST <= BURST_INCR;
              ARID    <= cmd_id;
              state   <= S_AR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_AW: begin
          if (aw_hs) begin
            AWVALID <= 1'b0;
            state   <= S_WDATA;
          end
        end
        S_WDATA: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (beat_cnt == len_q) begin
              BREADY <= 1'b1;
              state  <= S_BRESP;
            end
          end
        end
        S_BRESP: begin
          if (b_hs) begin
            BREADY    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_resp  <= BRESP;
            state     <= S_IDLE;
          end
        end
        S_AR: begin
          if (ar_hs) begin
            ARVALID <= 1'b0;
            state   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            resp_acc <= resp_next;
            if (RLAST) begin
              rsp_valid <= 1'b1;
              rsp_resp  <= resp_next;
              state     <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
`ifdef AXI4_MASTER_TIMEOUT_EN
      // A stalled burst is abandoned and reported as a slave error.
      if (wd_hit) begin
        state     <= S_IDLE;
        AWVALID   <= 1'b0;
        ARVALID   <= 1'b0;
        BREADY    <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_resp  <= 2'b10;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi4_burst_master.sv
// tb_axi4_burst_master: drives commands and acts as the AXI4 slave plus the
// data-stream endpoints of axi4_burst_master. Beats are pushed to exp_q when
// the bench sources them and popped/compared where the DUT delivers them.
module tb_axi4_burst_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int SW = DW / 8;
  localparam int EW = 1 + SW + DW;
  localparam int TO_CYCLES = 16;

  logic          ACLK, ARESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [IW-1:0] cmd_id;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic          rsp_valid;
  logic [1:0]    rsp_resp;
  logic          AWVALID, AWREADY, ARVALID, ARREADY;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [7:0]    AWLEN, ARLEN;
  logic [2:0]    AWSIZE, ARSIZE;
  logic [1:0]    AWBURST, ARBURST;
  logic [IW-1:0] AWID, ARID, BID, RID;
  logic          WVALID, WREADY, WLAST;
  logic [DW-1:0] WDATA, RDATA;
  logic [SW-1:0] WSTRB;
  logic          BVALID, BREADY, RVALID, RREADY, RLAST;
  logic [1:0]    BRESP, RRESP;
  logic [2:0]    fsm_state;
`ifdef AXI4_MASTER_TIMEOUT_EN
  logic          err_timeout;
`endif

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  // observations captured by the driver tasks
  logic [AW-1:0] o_addr;
  logic [7:0]    o_len;
  logic [2:0]    o_size;
  logic [1:0]    o_burst;
  logic [IW-1:0] o_id;
  logic [1:0]    o_rsp_resp;
  logic          o_ready_at_rsp;
  int o_beats, o_wait, o_unstable, o_early, o_cmd_wait, o_rsp_lat, o_rsp_seen, o_busy_ready;

  axi4_burst_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TO_CYCLES)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .rsp_valid(rsp_valid), .rsp_resp(rsp_resp),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWID(AWID),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARID(ARID),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .RLAST(RLAST), .RID(RID),
    .fsm_state(fsm_state)
`ifdef AXI4_MASTER_TIMEOUT_EN
    , .err_timeout(err_timeout)
`endif
  );

  // clock
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
    wr_valid = 0; wr_data = '0; wr_strb = '0; rd_ready = 0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = '0; BID = '0;
    ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = '0; RLAST = 0; RID = '0;
  endtask

  // Present one command; returns at the cycle after it was accepted.
  task automatic issue_cmd(input bit wr, input [AW-1:0] addr, input [7:0] len, input [IW-1:0] id);
    int n;
    n = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
    @(negedge ACLK);
    while (!cmd_ready && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    o_cmd_wait = n;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
    end
    @(posedge ACLK); #1;
    cmd_valid = 0;
  endtask

  // Write transaction with slave-side AW delay and optional toggling WREADY.
  task automatic do_write(input [AW-1:0] addr, input [7:0] len, input [IW-1:0] id,
                          input [1:0] bresp, input int aw_delay, input bit wtoggle);
    int sent, cyc, b_cyc;
    bit aw_done, w_done, b_done, aw_seen;
    logic [DW-1:0] cur;
    logic [EW-1:0] exp_item;
    sent = 0; cyc = 0; b_cyc = -100;
    aw_done = 0; w_done = 0; b_done = 0; aw_seen = 0;
    cur = $urandom;
    o_beats = 0; o_wait = 0; o_unstable = 0; o_early = 0; o_rsp_seen = 0;
    o_busy_ready = 0; o_rsp_lat = -1; o_rsp_resp = 2'bxx; o_ready_at_rsp = 1'bx;
    issue_cmd(1'b1, addr, len, id);
    while (!o_rsp_seen && cyc < 400) begin
      AWREADY  = (o_wait >= aw_delay);
      WREADY   = wtoggle ? cyc[0] : 1'b1;
      wr_valid = !w_done && ($urandom_range(0, 3) != 0);
      wr_data  = cur;
      wr_strb  = SW'(cur >> 7);
      BVALID   = w_done && !b_done;
      BRESP    = bresp;
      BID      = id;
      @(negedge ACLK);
      if (cmd_ready && !rsp_valid) o_busy_ready++;
      if (rsp_valid) begin
        o_rsp_seen = 1; o_rsp_resp = rsp_resp; o_rsp_lat = cyc - b_cyc; o_ready_at_rsp = cmd_ready;
      end
      if (WVALID && !aw_done) o_early++;
      if (AWVALID && !aw_done) begin
        if (!aw_seen) begin
          aw_seen = 1; o_addr = AWADDR; o_len = AWLEN; o_size = AWSIZE; o_burst = AWBURST; o_id = AWID;
        end else if ({AWADDR, AWLEN, AWSIZE, AWBURST, AWID} !== {o_addr, o_len, o_size, o_burst, o_id}) begin
          o_unstable++;
        end
        if (AWREADY) aw_done = 1;
        else o_wait++;
      end
      if (wr_valid && wr_ready) begin
        exp_q.push_back({(sent == int'(len)), wr_strb, cur});
        sent++;
        cur = $urandom;
        if (sent > int'(len)) w_done = 1;
      end
      if (WVALID && WREADY) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL w_beat: W handshake with last=%b data=%h, required no beat", WLAST, WDATA);
        end else begin
          exp_item = exp_q.pop_front();
          if ({WLAST, WSTRB, WDATA} !== exp_item) begin
            failures++;
            $display("FAIL w_beat: got last/strb/data=%h, required %h", {WLAST, WSTRB, WDATA}, exp_item);
          end
          o_beats++;
        end
      end
      if (BVALID && BREADY) begin b_done = 1; b_cyc = cyc; end
      @(posedge ACLK); #1;
      cyc++;
    end
    AWREADY = 0; WREADY = 0; wr_valid = 0; BVALID = 0;
    checks++;
    if (!o_rsp_seen) begin
      failures++;
      $display("FAIL write_done: rsp_valid not seen within %0d cycles, required a pulse", cyc);
    end
  endtask

  // Read transaction; beat err_beat returns SLVERR; stops early after abort_at beats.
  task automatic do_read(input [AW-1:0] addr, input [7:0] len, input [IW-1:0] id,
                         input int err_beat, input int abort_at);
    int rs, got, cyc;
    bit ar_done, ar_seen;
    logic [DW-1:0] cur;
    logic [SW-1:0] zs;
    logic [EW-1:0] exp_item;
    rs = 0; got = 0; cyc = 0; ar_done = 0; ar_seen = 0; zs = '0;
    cur = $urandom;
    o_beats = 0; o_rsp_seen = 0; o_busy_ready = 0; o_rsp_resp = 2'bxx;
    issue_cmd(1'b0, addr, len, id);
    while (!o_rsp_seen && cyc < 400 && got != abort_at) begin
      ARREADY  = ($urandom_range(0, 1) == 1);
      RVALID   = ar_done && (rs <= int'(len)) && ($urandom_range(0, 3) != 0);
      RDATA    = cur;
      RRESP    = (rs == err_beat) ? 2'b10 : 2'b00;
      RLAST    = (rs == int'(len));
      RID      = id;
      rd_ready = ($urandom_range(0, 3) != 0);
      @(negedge ACLK);
      if (cmd_ready && !rsp_valid) o_busy_ready++;
      if (rsp_valid) begin o_rsp_seen = 1; o_rsp_resp = rsp_resp; end
      if (ARVALID && !ar_done) begin
        if (!ar_seen) begin
          ar_seen = 1; o_addr = ARADDR; o_len = ARLEN; o_size = ARSIZE; o_burst = ARBURST; o_id = ARID;
        end
        if (ARREADY) ar_done = 1;
      end
      if (RVALID && RREADY) begin
        exp_q.push_back({(rs == int'(len)), zs, cur});
        rs++;
        cur = $urandom;
      end
      if (rd_valid && rd_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rd_beat: rd beat last=%b data=%h, required no beat", rd_last, rd_data);
        end else begin
          exp_item = exp_q.pop_front();
          if ({rd_last, zs, rd_data} !== exp_item) begin
            failures++;
            $display("FAIL rd_beat: got last/data=%h, required %h", {rd_last, zs, rd_data}, exp_item);
          end
          got++;
          o_beats++;
        end
      end
      @(posedge ACLK); #1;
      cyc++;
    end
    if (abort_at < 0) begin
      ARREADY = 0; RVALID = 0; rd_ready = 0; RLAST = 0;
      checks++;
      if (!o_rsp_seen) begin
        failures++;
        $display("FAIL read_done: rsp_valid not seen within %0d cycles, required a pulse", cyc);
      end
    end
  endtask

  task automatic test_reset();
    ARESETn = 0;
    idle_inputs();
    wr_valid = 1; WREADY = 1; RVALID = 1; rd_ready = 1; RLAST = 1; RDATA = 32'hdead_beef; wr_data = 32'h1234_5678;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    checks++;
    if ({cmd_ready, AWVALID, ARVALID, WVALID, wr_ready, BREADY, RREADY, rd_valid, rd_last, rsp_valid, WLAST} !== 11'b0) begin
      failures++;
      $display("FAIL reset_ctrl: handshake outputs=%b, required 0", {cmd_ready, AWVALID, ARVALID, WVALID, wr_ready, BREADY, RREADY, rd_valid, rd_last, rsp_valid, WLAST});
    end
    checks++;
    if ({AWADDR, AWLEN, AWSIZE, AWBURST, AWID, ARADDR, ARLEN, ARSIZE, ARBURST, ARID, WDATA, WSTRB, rd_data, rsp_resp} !== '0) begin
      failures++;
      $display("FAIL reset_payload: payload outputs not zero (AWADDR=%h ARADDR=%h WDATA=%h rd_data=%h), required 0", AWADDR, ARADDR, WDATA, rd_data);
    end
    checks++;
    if (fsm_state !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: fsm_state=%0d, required 0", fsm_state);
    end
    idle_inputs();
    ARESETn = 1;
    @(negedge ACLK);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: cmd_ready=%b one cycle after release, required 1", cmd_ready);
    end
    @(posedge ACLK); #1;
  endtask

  task automatic test_write_burst();
    do_write(32'h100, 8'd3, 4'd5, 2'b00, 0, 1'b0);
    checks++;
    if ({o_addr, o_len, o_size, o_burst, o_id} !== {32'h100, 8'd3, 3'd2, 2'b01, 4'd5}) begin
      failures++;
      $display("FAIL wr_aw_payload: addr=%h len=%0d size=%0d burst=%b id=%0d, required 100/3/2/01/5", o_addr, o_len, o_size, o_burst, o_id);
    end
    checks++;
    if (o_beats !== 4) begin failures++; $display("FAIL wr_beats: %0d beats, required 4", o_beats); end
    checks++;
    if (o_rsp_resp !== 2'b00) begin failures++; $display("FAIL wr_resp: rsp_resp=%b, required 00", o_rsp_resp); end
    checks++;
    if (o_rsp_lat !== 1) begin failures++; $display("FAIL wr_rsp_latency: %0d cycles after B, required 1", o_rsp_lat); end
    checks++;
    if (o_busy_ready !== 0) begin failures++; $display("FAIL wr_cmd_busy: cmd_ready high %0d cycles in burst, required 0", o_busy_ready); end
    @(negedge ACLK);
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      failures++;
      $display("FAIL wr_rsp_pulse: rsp_valid/cmd_ready=%b after completion, required 01", {rsp_valid, cmd_ready});
    end
    @(posedge ACLK); #1;
    // error response passes through unchanged
    do_write(32'h2040, 8'd1, 4'd7, 2'b10, 1, 1'b0);
    checks++;
    if (o_rsp_resp !== 2'b10) begin failures++; $display("FAIL wr_slverr: rsp_resp=%b, required 10", o_rsp_resp); end
  endtask

  task automatic test_read_burst();
    do_read(32'h3000, 8'd7, 4'd9, 2, -1);
    checks++;
    if ({o_addr, o_len, o_size, o_burst, o_id} !== {32'h3000, 8'd7, 3'd2, 2'b01, 4'd9}) begin
      failures++;
      $display("FAIL rd_ar_payload: addr=%h len=%0d size=%0d burst=%b id=%0d, required 3000/7/2/01/9", o_addr, o_len, o_size, o_burst, o_id);
    end
    checks++;
    if (o_beats !== 8) begin failures++; $display("FAIL rd_beats: %0d beats, required 8", o_beats); end
    checks++;
    if (o_rsp_resp !== 2'b10) begin failures++; $display("FAIL rd_worst_resp: rsp_resp=%b, required 10", o_rsp_resp); end
    checks++;
    if (o_busy_ready !== 0) begin failures++; $display("FAIL rd_cmd_busy: cmd_ready high %0d cycles in burst, required 0", o_busy_ready); end
    // clean read: accumulated response must not carry over from the last burst
    do_read(32'h3400, 8'd2, 4'd1, 1000, -1);
    checks++;
    if ({o_beats, o_rsp_resp} !== {32'd3, 2'b00}) begin
      failures++;
      $display("FAIL rd_clean: beats=%0d resp=%b, required 3 and 00", o_beats, o_rsp_resp);
    end
  endtask

  task automatic test_stall();
    do_write(32'h40, 8'd5, 4'd3, 2'b00, 5, 1'b1);
    checks++;
    if (o_unstable !== 0) begin failures++; $display("FAIL aw_stable: AW payload changed %0d times while stalled, required 0", o_unstable); end
    checks++;
    if (o_wait !== 5) begin failures++; $display("FAIL aw_stall: AWVALID waited %0d cycles, required 5", o_wait); end
    checks++;
    if (o_early !== 0) begin failures++; $display("FAIL w_before_aw: WVALID high %0d cycles before AW handshake, required 0", o_early); end
    checks++;
    if (o_beats !== 6) begin failures++; $display("FAIL stall_beats: %0d beats, required 6", o_beats); end
  endtask

  task automatic test_back_to_back();
    do_write(32'h80, 8'd0, 4'd2, 2'b00, 0, 1'b0);
    checks++;
    if (o_beats !== 1) begin failures++; $display("FAIL len0_beats: %0d beats, required 1", o_beats); end
    checks++;
    if (o_ready_at_rsp !== 1'b0) begin failures++; $display("FAIL b2b_ready_at_rsp: cmd_ready=%b with rsp_valid, required 0", o_ready_at_rsp); end
    do_read(32'h300, 8'd0, 4'd11, 1000, -1);
    checks++;
    if (o_cmd_wait !== 0) begin failures++; $display("FAIL b2b_accept: read waited %0d cycles after rsp, required 0", o_cmd_wait); end
    checks++;
    if ({o_id, o_addr} !== {4'd11, 32'h300}) begin failures++; $display("FAIL b2b_arid: ARID=%0d ARADDR=%h, required 11 and 300", o_id, o_addr); end
    checks++;
    if (o_beats !== 1) begin failures++; $display("FAIL b2b_rd_beats: %0d beats, required 1", o_beats); end
  endtask

  task automatic test_reset_mid_burst();
    int pulses;
    pulses = 0;
    do_read(32'h400, 8'd7, 4'd6, 1000, 2);
    RVALID = 1; RLAST = 0; RDATA = 32'hcafe_f00d; rd_ready = 1;
    #2;
    ARESETn = 0;
    #1;
    checks++;
    if ({rd_valid, RREADY, ARVALID, AWVALID, cmd_ready, rsp_valid, rd_last} !== 7'b0 || rd_data !== '0) begin
      failures++;
      $display("FAIL async_reset: rd_valid/RREADY/ARVALID/AWVALID/cmd_ready/rsp_valid/rd_last=%b rd_data=%h, required 0",
               {rd_valid, RREADY, ARVALID, AWVALID, cmd_ready, rsp_valid, rd_last}, rd_data);
    end
    checks++;
    if ({ARADDR, ARLEN, fsm_state} !== '0) begin
      failures++;
      $display("FAIL async_reset_regs: ARADDR=%h ARLEN=%0d state=%0d, required 0", ARADDR, ARLEN, fsm_state);
    end
    @(posedge ACLK);
    @(negedge ACLK);
    idle_inputs();
    ARESETn = 1;
    exp_q.delete();
    @(negedge ACLK);
    if (rsp_valid) pulses++;
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_release: cmd_ready=%b, required 1", cmd_ready); end
    repeat (3) begin
      @(negedge ACLK);
      if (rsp_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL mid_reset_no_rsp: %0d completion pulses, required 0", pulses); end
    @(posedge ACLK); #1;
  endtask

`ifdef AXI4_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    do_write(32'h500, 8'd1, 4'd1, 2'b00, 100000, 1'b0);
    checks++;
    if (o_wait !== TO_CYCLES) begin failures++; $display("FAIL timeout_cycles: AWVALID stalled %0d cycles, required %0d", o_wait, TO_CYCLES); end
    checks++;
    if (o_rsp_resp !== 2'b10) begin failures++; $display("FAIL timeout_resp: rsp_resp=%b, required 10", o_rsp_resp); end
    @(negedge ACLK);
    checks++;
    if ({err_timeout, cmd_ready, AWVALID} !== 3'b110) begin
      failures++;
      $display("FAIL timeout_idle: err_timeout/cmd_ready/AWVALID=%b, required 110", {err_timeout, cmd_ready, AWVALID});
    end
    @(posedge ACLK); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_stall();
    test_back_to_back();
    test_reset_mid_burst();
`ifdef AXI4_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d beats left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
